// File: rtl/tlb.sv
// Fully associative 16-entry TLB with two combinational search ports, a
// combinational read port, a write port and invtlb invalidation.
// Optional feature macro: TLB_PS4MB_EN enables 4MB (ps==21) page matching;
// without it every entry is matched as a 4KB page.
module tlb #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic        clk,
  input  logic        reset,
  // search port 0
  input  logic [18:0] s0_vppn,
  input  logic        s0_va_bit12,
  input  logic [9:0]  s0_asid,
  output logic        s0_found,
  output logic [3:0]  s0_index,
  output logic [19:0] s0_ppn,
  output logic [5:0]  s0_ps,
  output logic [1:0]  s0_plv,
  output logic [1:0]  s0_mat,
  output logic        s0_d,
  output logic        s0_v,
  // search port 1
  input  logic [18:0] s1_vppn,
  input  logic        s1_va_bit12,
  input  logic [9:0]  s1_asid,
  output logic        s1_found,
  output logic [3:0]  s1_index,
  output logic [19:0] s1_ppn,
  output logic [5:0]  s1_ps,
  output logic [1:0]  s1_plv,
  output logic [1:0]  s1_mat,
  output logic        s1_d,
  output logic        s1_v,
  // invalidate
  input  logic        invtlb_valid,
  input  logic [4:0]  invtlb_op,
  // write port
  input  logic        we,
  input  logic [3:0]  w_index,
  input  logic        w_e,
  input  logic [18:0] w_vppn,
  input  logic [5:0]  w_ps,
  input  logic [9:0]  w_asid,
  input  logic        w_g,
  input  logic [19:0] w_ppn0,
  input  logic [1:0]  w_plv0,
  input  logic [1:0]  w_mat0,
  input  logic        w_d0,
  input  logic        w_v0,
  input  logic [19:0] w_ppn1,
  input  logic [1:0]  w_plv1,
  input  logic [1:0]  w_mat1,
  input  logic        w_d1,
  input  logic        w_v1,
  // read port
  input  logic [3:0]  r_index,
  output logic        r_e,
  output logic [18:0] r_vppn,
  output logic [5:0]  r_ps,
  output logic [9:0]  r_asid,
  output logic        r_g,
  output logic [19:0] r_ppn0,
  output logic [1:0]  r_plv0,
  output logic [1:0]  r_mat0,
  output logic        r_d0,
  output logic        r_v0,
  output logic [19:0] r_ppn1,
  output logic [1:0]  r_plv1,
  output logic [1:0]  r_mat1,
  output logic        r_d1,
  output logic        r_v1
);

  localparam int unsigned IDXW = 4;
  localparam int unsigned PGW  = 26;  // {ppn, plv, mat, d, v}

  logic [TLBNUM-1:0] e_q, e_d;
  logic [TLBNUM-1:0] g_q;
  logic [5:0]        ps_q   [TLBNUM];
  logic [18:0]       vppn_q [TLBNUM];
  logic [9:0]        asid_q [TLBNUM];
  logic [PGW-1:0]    pg0_q  [TLBNUM];
  logic [PGW-1:0]    pg1_q  [TLBNUM];

  logic [TLBNUM-1:0] big;     // entry is treated as a 4MB page
  logic [TLBNUM-1:0] match0;
  logic [TLBNUM-1:0] match1;
  logic [TLBNUM-1:0] am1;     // asid match against port 1 operand
  logic [TLBNUM-1:0] vhit1;   // VA match against port 1 operand
  logic [TLBNUM-1:0] inv_sel;

  logic [IDXW-1:0]   s0_idx, s1_idx;
  logic              s0_odd, s1_odd;
  logic [PGW-1:0]    s0_pg, s1_pg;

  // Lowest-index hit wins.
  function automatic logic [IDXW-1:0] first_hit(input logic [TLBNUM-1:0] m);
    first_hit = '0;
    for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
      if (m[i]) first_hit = IDXW'(i);
    end
  endfunction

  // Per-entry tag compare for both search ports and the invtlb operands.
  for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_ent
    logic vhit0;
`ifdef TLB_PS4MB_EN
    assign big[gi] = (ps_q[gi] == 6'd21);
`else
    assign big[gi] = 1'b0;
`endif
    assign vhit0      = big[gi] ? (vppn_q[gi][18:9] == s0_vppn[18:9]) : (vppn_q[gi] == s0_vppn);
    assign vhit1[gi]  = big[gi] ? (vppn_q[gi][18:9] == s1_vppn[18:9]) : (vppn_q[gi] == s1_vppn);
    assign am1[gi]    = (asid_q[gi] == s1_asid);
    assign match0[gi] = e_q[gi] & (g_q[gi] | (asid_q[gi] == s0_asid)) & vhit0;
    assign match1[gi] = e_q[gi] & (g_q[gi] | am1[gi]) & vhit1[gi];
  end

  // Entries selected by the invtlb opcode; unknown opcodes select nothing.
  always_comb begin
    inv_sel = '0;
    case (invtlb_op)
      5'd0, 5'd1: inv_sel = '1;
      5'd2:       inv_sel = g_q;
      5'd3:       inv_sel = ~g_q;
      5'd4:       inv_sel = ~g_q & am1;
      5'd5:       inv_sel = ~g_q & am1 & vhit1;
      5'd6:       inv_sel = (g_q | am1) & vhit1;
      default:    inv_sel = '0;
    endcase
  end

  // Valid-bit next state: invalidate first, then the write lands on top.
  always_comb begin
    e_d = e_q;
    if (invtlb_valid) e_d = e_d & ~inv_sel;
    if (we)           e_d[w_index] = w_e;
  end

  // Valid bits are the only reset state.
  always_ff @(posedge clk) begin
    if (reset) e_q <= '0;
    else       e_q <= e_d;
  end

  // Entry payload storage; a write is dropped while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      g_q[w_index]    <= w_g;
      ps_q[w_index]   <= w_ps;
      vppn_q[w_index] <= w_vppn;
      asid_q[w_index] <= w_asid;
      pg0_q[w_index]  <= {w_ppn0, w_plv0, w_mat0, w_d0, w_v0};
      pg1_q[w_index]  <= {w_ppn1, w_plv1, w_mat1, w_d1, w_v1};
    end
  end

  // Search port 0 result; all fields zero on a miss.
  always_comb begin
    s0_idx   = first_hit(match0);
    s0_odd   = big[s0_idx] ? s0_vppn[8] : s0_va_bit12;
    s0_pg    = s0_odd ? pg1_q[s0_idx] : pg0_q[s0_idx];
    s0_found = (|match0) & ~reset;
    s0_index = '0;
    s0_ps    = '0;
    {s0_ppn, s0_plv, s0_mat, s0_d, s0_v} = '0;
    if (s0_found) begin
      s0_index = s0_idx;
      s0_ps    = ps_q[s0_idx];
      {s0_ppn, s0_plv, s0_mat, s0_d, s0_v} = s0_pg;
    end
  end

  // Search port 1 result; all fields zero on a miss.
  always_comb begin
    s1_idx   = first_hit(match1);
    s1_odd   = big[s1_idx] ? s1_vppn[8] : s1_va_bit12;
    s1_pg    = s1_odd ? pg1_q[s1_idx] : pg0_q[s1_idx];
    s1_found = (|match1) & ~reset;
    s1_index = '0;
    s1_ps    = '0;
    {s1_ppn, s1_plv, s1_mat, s1_d, s1_v} = '0;
    if (s1_found) begin
      s1_index = s1_idx;
      s1_ps    = ps_q[s1_idx];
      {s1_ppn, s1_plv, s1_mat, s1_d, s1_v} = s1_pg;
    end
  end

  // Read port returns the current (pre-write) contents.
  assign r_e    = e_q[r_index] & ~reset;
  assign r_vppn = vppn_q[r_index];
  assign r_ps   = ps_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign {r_ppn0, r_plv0, r_mat0, r_d0, r_v0} = pg0_q[r_index];
  assign {r_ppn1, r_plv1, r_mat1, r_d1, r_v1} = pg1_q[r_index];

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed scenarios followed by random traffic,
// all compared against an entry-table reference model.
module tb_tlb;

  logic clk = 1'b0;
  logic reset;
  logic [18:0] s0_vppn, s1_vppn;
  logic        s0_va_bit12, s1_va_bit12;
  logic [9:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0]  s0_ps, s1_ps;
  logic [1:0]  s0_plv, s0_mat, s1_plv, s1_mat;
  logic        s0_d, s0_v, s1_d, s1_v;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic        we, w_e, w_g;
  logic [3:0]  w_index;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
  logic        w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  r_index;
  logic        r_e, r_g;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
  logic        r_d0, r_v0, r_d1, r_v1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        e;
    logic [5:0]  ps;
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic        g;
    logic [25:0] pg0;  // {ppn, plv, mat, d, v}
    logic [25:0] pg1;
  } ent_t;

  ent_t        m [16];
  logic [15:0] m_wr;   // entry payload has been written at least once

  tlb dut (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
    .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
    .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .we(we), .w_index(w_index), .w_e(w_e), .w_ps(w_ps), .w_vppn(w_vppn),
    .w_asid(w_asid), .w_g(w_g),
    .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
    .r_g(r_g), .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0),
    .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1),
    .r_v1(r_v1)
  );

  always #5 clk = ~clk;

  function automatic logic is_4m(input logic [5:0] ps);
`ifdef TLB_PS4MB_EN
    return ps == 6'd21;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic va_hit(input ent_t en, input logic [18:0] qv);
    if (is_4m(en.ps)) return en.vppn[18:9] == qv[18:9];
    return en.vppn == qv;
  endfunction

  // Expected {found, index, ppn, ps, plv, mat, d, v} for a query.
  function automatic logic [36:0] model_search(input logic [18:0] qv, input logic b12,
                                               input logic [9:0] qa);
    logic odd;
    logic [25:0] pg;
    if (reset) return '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i].e && (m[i].g || m[i].asid == qa) && va_hit(m[i], qv)) begin
        odd = is_4m(m[i].ps) ? qv[8] : b12;
        pg  = odd ? m[i].pg1 : m[i].pg0;
        return {1'b1, 4'(i), pg[25:6], m[i].ps, pg[5:0]};
      end
    end
    return '0;
  endfunction

  function automatic logic inv_hit(input logic [4:0] op, input ent_t en);
    logic am, va;
    am = (en.asid == s1_asid);
    va = va_hit(en, s1_vppn);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return en.g;
      5'd3:       return !en.g;
      5'd4:       return !en.g && am;
      5'd5:       return !en.g && am && va;
      5'd6:       return (en.g || am) && va;
      default:    return 1'b0;
    endcase
  endfunction

  // Apply the clock-edge effect of the current inputs to the model.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 16; i++) m[i].e = 1'b0;
    end else begin
      if (invtlb_valid)
        for (int i = 0; i < 16; i++) if (inv_hit(invtlb_op, m[i])) m[i].e = 1'b0;
      if (we) begin
        m[w_index] = '{e: w_e, ps: w_ps, vppn: w_vppn, asid: w_asid, g: w_g,
                       pg0: {w_ppn0, w_plv0, w_mat0, w_d0, w_v0},
                       pg1: {w_ppn1, w_plv1, w_mat1, w_d1, w_v1}};
        m_wr[w_index] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".s0"},
        128'({s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v}),
        128'(model_search(s0_vppn, s0_va_bit12, s0_asid)));
    chk({tag, ".s1"},
        128'({s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v}),
        128'(model_search(s1_vppn, s1_va_bit12, s1_asid)));
    chk({tag, ".r_e"}, 128'(r_e), 128'(m[r_index].e & ~reset));
    if (m_wr[r_index])
      chk({tag, ".rd"},
          128'({r_vppn, r_ps, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
                r_ppn1, r_plv1, r_mat1, r_d1, r_v1}),
          128'({m[r_index].vppn, m[r_index].ps, m[r_index].asid, m[r_index].g,
                m[r_index].pg0, m[r_index].pg1}));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    we = 1'b0;
    invtlb_valid = 1'b0;
  endtask

  function automatic ent_t mk_ent(input logic e, input logic [5:0] ps, input logic [18:0] vppn,
                                  input logic [9:0] asid, input logic g,
                                  input logic [19:0] ppn0, input logic [19:0] ppn1);
    ent_t en;
    en.e = e; en.ps = ps; en.vppn = vppn; en.asid = asid; en.g = g;
    en.pg0 = {ppn0, 2'($urandom), 2'($urandom), 1'($urandom), 1'b1};
    en.pg1 = {ppn1, 2'($urandom), 2'($urandom), 1'($urandom), 1'b1};
    return en;
  endfunction

  task automatic drive_write(input logic [3:0] idx, input ent_t en);
    we = 1'b1; w_index = idx; w_e = en.e; w_ps = en.ps; w_vppn = en.vppn;
    w_asid = en.asid; w_g = en.g;
    {w_ppn0, w_plv0, w_mat0, w_d0, w_v0} = en.pg0;
    {w_ppn1, w_plv1, w_mat1, w_d1, w_v1} = en.pg1;
  endtask

  task automatic q0(input logic [18:0] v, input logic b, input logic [9:0] a);
    s0_vppn = v; s0_va_bit12 = b; s0_asid = a;
  endtask

  task automatic q1(input logic [18:0] v, input logic b, input logic [9:0] a);
    s1_vppn = v; s1_va_bit12 = b; s1_asid = a;
  endtask

  function automatic logic [18:0] rnd_vppn();
    logic [8:0] lo;
    lo = 9'($urandom_range(0, 3));
    lo[8] = 1'($urandom);
    return {10'($urandom_range(0, 3)), lo};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) m[i] = '0;
    m_wr = '0;
    reset = 1'b1; we = 1'b0; invtlb_valid = 1'b0; invtlb_op = '0;
    drive_write(4'd0, '0); we = 1'b0;
    q0('0, 1'b0, '0); q1('0, 1'b0, '0); r_index = '0;

    // Outputs quiet while reset is held.
    check_all("rst_hold");
    chk("rst_hold.found", 128'({s0_found, s1_found, r_e}), 128'(0));
    step(); step();
    reset = 1'b0;
    check_all("post_rst");

    // 4KB hit on idx3, odd page via va_bit12; read shows pre-write state.
    drive_write(4'd3, mk_ent(1'b1, 6'd12, 19'h00010, 10'd5, 1'b0, 20'h111, 20'h222));
    r_index = 4'd3;
    check_all("w3_same");
    chk("w3_same.r_e", 128'(r_e), 128'(0));
    step();
    q0(19'h00010, 1'b1, 10'd5);
    check_all("hit3");
    chk("hit3.const", 128'({s0_found, s0_index, s0_ppn}), 128'({1'b1, 4'd3, 20'h222}));

    // ASID mismatch, then global entry hits any ASID.
    q0(19'h00010, 1'b1, 10'd6);
    check_all("asid6");
    chk("asid6.found", 128'(s0_found), 128'(0));
    drive_write(4'd3, mk_ent(1'b1, 6'd12, 19'h00010, 10'd5, 1'b1, 20'h111, 20'h222));
    step();
    check_all("glob");
    chk("glob.found", 128'(s0_found), 128'(1));

`ifdef TLB_PS4MB_EN
    // 4MB page: upper VPPN compare, vppn[8] selects the page.
    drive_write(4'd7, mk_ent(1'b1, 6'd21, 19'h40000, 10'd5, 1'b0, 20'h777, 20'h778));
    step();
    q0(19'h400FF, 1'b0, 10'd5);
    check_all("4m_even");
    chk("4m_even.const", 128'({s0_found, s0_index, s0_ppn}), 128'({1'b1, 4'd7, 20'h777}));
    q0(19'h401FF, 1'b0, 10'd5);
    check_all("4m_odd");
    chk("4m_odd.const", 128'({s0_found, s0_index, s0_ppn}), 128'({1'b1, 4'd7, 20'h778}));
`endif

    // invtlb op3 clears only non-global entries, op0 clears all.
    drive_write(4'd1, mk_ent(1'b1, 6'd12, 19'h00100, 10'd1, 1'b1, 20'h1, 20'h2));
    step();
    drive_write(4'd2, mk_ent(1'b1, 6'd12, 19'h00200, 10'd9, 1'b0, 20'h3, 20'h4));
    step();
    invtlb_valid = 1'b1; invtlb_op = 5'd3;
    step();
    r_index = 4'd2;
    check_all("op3.i2");
    chk("op3.i2e", 128'(r_e), 128'(0));
    r_index = 4'd1;
    check_all("op3.i1");
    chk("op3.i1e", 128'(r_e), 128'(1));
    invtlb_valid = 1'b1; invtlb_op = 5'd0;
    step();
    check_all("op0.i1");
    chk("op0.i1e", 128'(r_e), 128'(0));

    // op5 plus same-cycle write to the invalidated entry.
    drive_write(4'd4, mk_ent(1'b1, 6'd12, 19'h00020, 10'd9, 1'b0, 20'h40, 20'h41));
    step();
    drive_write(4'd5, mk_ent(1'b1, 6'd12, 19'h00030, 10'd9, 1'b0, 20'h50, 20'h51));
    step();
    q1(19'h00020, 1'b0, 10'd9);
    invtlb_valid = 1'b1; invtlb_op = 5'd5;
    drive_write(4'd4, mk_ent(1'b1, 6'd12, 19'h00020, 10'd9, 1'b0, 20'h444, 20'h445));
    step();
    r_index = 4'd4;
    check_all("op5we.i4");
    chk("op5we.i4c", 128'({r_e, r_ppn0}), 128'({1'b1, 20'h444}));
    r_index = 4'd5;
    check_all("op5we.i5");
    chk("op5we.i5e", 128'(r_e), 128'(1));

    // Lowest index wins on a double hit; reset kills all hits.
    drive_write(4'd8, mk_ent(1'b1, 6'd12, 19'h00055, 10'd2, 1'b0, 20'h88, 20'h89));
    step();
    drive_write(4'd0, mk_ent(1'b1, 6'd12, 19'h00055, 10'd2, 1'b0, 20'h10, 20'h11));
    step();
    q0(19'h00055, 1'b0, 10'd2); q1(19'h00055, 1'b1, 10'd2);
    check_all("dual");
    chk("dual.idx", 128'({s0_found, s0_index, s1_found, s1_index}),
        128'({1'b1, 4'd0, 1'b1, 4'd0}));
    reset = 1'b1;
    drive_write(4'd9, mk_ent(1'b1, 6'd12, 19'h00055, 10'd2, 1'b0, 20'h99, 20'h9A));
    step();
    check_all("rst_mid");
    reset = 1'b0;
    check_all("rst_after");
    chk("rst_after.found", 128'({s0_found, s1_found}), 128'(0));

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0)
        drive_write(4'($urandom), mk_ent(1'($urandom_range(0, 3) != 0),
                    $urandom_range(0, 1) ? 6'd21 : 6'd12, rnd_vppn(),
                    10'($urandom_range(0, 3)), 1'($urandom), 20'($urandom), 20'($urandom)));
      if ($urandom_range(0, 7) == 0) begin
        invtlb_valid = 1'b1;
        invtlb_op = 5'($urandom_range(0, 9));
      end
      q0(rnd_vppn(), 1'($urandom), 10'($urandom_range(0, 3)));
      q1(rnd_vppn(), 1'($urandom), 10'($urandom_range(0, 3)));
      r_index = 4'($urandom);
      check_all("rnd");
      step();
    end
    reset = 1'b0;
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
